// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: serial line, frame configuration and frame results of the UART RX frame controller
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic [DATA_W-1:0]     p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;
    logic                  busy;

    modport master (
        input  rx_in, prescale, par_en, par_typ, stop2,
        output p_data, data_valid, par_err, stp_err, strt_glitch, busy
    );

    modport slave (
        output rx_in, prescale, par_en, par_typ, stop2,
        input  p_data, data_valid, par_err, stp_err, strt_glitch, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampling UART receiver with majority vote, optional parity and one/two stop-bit checks
module uart_rx_frame_ctrl #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input logic                  clk,
    input logic                  rst_n,
    uart_rx_frame_ctrl_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;
    localparam logic [3:0] BIT_LAST = 4'(DATA_W - 1);
    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);

    logic [2:0]            state, state_n;
    logic [PRESCALE_W-1:0] p_l, edge_cnt, half, p_eff;
    logic                  par_en_l, par_typ_l, stop2_l, par_bad;
    logic [3:0]            bit_cnt;
    logic [DATA_W-1:0]     sh;
    logic [2:0]            smp;
    logic                  last_edge, vote, in_stop, frame_end, starting;

    assign p_eff     = bus.prescale < P_MIN ? P_MIN : bus.prescale;
    assign half      = p_l >> 1;
    assign last_edge = edge_cnt == p_l - 1'b1;
    assign vote      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign in_stop   = state == STOP1 || state == STOP2;
    assign frame_end = in_stop && last_edge && vote && !(state == STOP1 && stop2_l);
    assign starting  = state_n == START && state != START;

    // Next-state decision; every bit-level decision is taken at last_edge on the voted bit
    always_comb begin
        state_n = state;
        case (state)
            IDLE:         if (!bus.rx_in) state_n = START;
            START:        if (last_edge) state_n = vote ? IDLE : DATA;
            DATA:         if (last_edge && bit_cnt == BIT_LAST) state_n = par_en_l ? PARITY : STOP1;
            PARITY:       if (last_edge) state_n = STOP1;
            STOP1, STOP2: if (last_edge) state_n = !vote ? ERROR :
                                                   !frame_end ? STOP2 :
                                                   !bus.rx_in ? START : IDLE;
            ERROR:        if (bus.rx_in && last_edge) state_n = IDLE;
            default:      state_n = IDLE;
        endcase
    end

    // Counters, sampler, deserialiser, frame config latch and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            p_l             <= P_MIN;
            edge_cnt        <= '0;
            bit_cnt         <= '0;
            sh              <= '0;
            smp             <= '0;
            par_en_l        <= 1'b0;
            par_typ_l       <= 1'b0;
            stop2_l         <= 1'b0;
            par_bad         <= 1'b0;
            bus.p_data      <= '0;
            bus.data_valid  <= 1'b0;
            bus.par_err     <= 1'b0;
            bus.stp_err     <= 1'b0;
            bus.strt_glitch <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_n;
            bus.busy        <= state_n != IDLE;
            bus.data_valid  <= 1'b0;
            bus.par_err     <= 1'b0;
            bus.stp_err     <= 1'b0;
            bus.strt_glitch <= 1'b0;
            edge_cnt <= (state == IDLE || starting || last_edge || (state == ERROR && !bus.rx_in))
                        ? '0 : edge_cnt + 1'b1;
            if (starting) begin
                p_l       <= p_eff;
                par_en_l  <= bus.par_en;
                par_typ_l <= bus.par_typ;
                stop2_l   <= bus.stop2;
                par_bad   <= 1'b0;
            end
            if (edge_cnt == half - 1'b1) smp[0] <= bus.rx_in;
            if (edge_cnt == half)        smp[1] <= bus.rx_in;
            if (edge_cnt == half + 1'b1) smp[2] <= bus.rx_in;
            if (state == START && last_edge && vote) bus.strt_glitch <= 1'b1;
            if (state == DATA && last_edge) begin
                sh      <= {vote, sh[DATA_W-1:1]};
                bit_cnt <= bit_cnt == BIT_LAST ? '0 : bit_cnt + 1'b1;
            end
            if (state == PARITY && last_edge) par_bad <= vote != (^sh ^ par_typ_l);
            if (in_stop && last_edge && !vote) begin
                bus.stp_err <= 1'b1;
                bus.par_err <= par_bad;
            end
            if (frame_end) begin
                if (par_bad) bus.par_err <= 1'b1;
                else begin
                    bus.p_data     <= sh;
                    bus.data_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: scoreboard bench for 8-bit and 9-bit receivers; events are predicted with their cycle and data
module tb_uart_rx_frame_ctrl;
    typedef struct {
        logic [3:0] fl;
        logic [8:0] d;
        int         cyc;
    } exp_t;

    localparam logic [3:0] VALID = 4'b1000;
    localparam logic [3:0] PERR  = 4'b0100;
    localparam logic [3:0] SERR  = 4'b0010;
    localparam logic [3:0] GLTCH = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         t;
    exp_t       q8[$], q9[$];
    logic [8:0] last8 = '0, last9 = '0;
    logic [3:0] fl8, fl9;

    uart_rx_frame_ctrl_if #(.DATA_W(8), .PRESCALE_W(6)) i8();
    uart_rx_frame_ctrl_if #(.DATA_W(9), .PRESCALE_W(6)) i9();

    uart_rx_frame_ctrl #(.DATA_W(8), .PRESCALE_W(6)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    uart_rx_frame_ctrl #(.DATA_W(9), .PRESCALE_W(6)) u9 (.clk(clk), .rst_n(rst_n), .bus(i9));

    assign fl8 = {i8.data_valid, i8.par_err, i8.stp_err, i8.strt_glitch};
    assign fl9 = {i9.data_valid, i9.par_err, i9.stp_err, i9.strt_glitch};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic score(input bit s9, input logic [3:0] fl, input logic [8:0] pd);
        exp_t e;
        if (s9 ? q9.size() == 0 : q8.size() == 0) begin
            check(s9 ? "spurious9" : "spurious8", 32'(fl), 32'(0));
            return;
        end
        e = s9 ? q9.pop_front() : q8.pop_front();
        check(s9 ? "flags9" : "flags8", 32'(fl), 32'(e.fl));
        check(s9 ? "cycle9" : "cycle8", 32'(cyc), 32'(e.cyc));
        check(s9 ? "p_data9" : "p_data8", 32'(pd), 32'(e.d));
    endtask

    always @(negedge clk) begin
        if (fl8 != 4'b0) score(1'b0, fl8, 9'(i8.p_data));
        if (fl9 != 4'b0) score(1'b1, fl9, i9.p_data);
    end

    task automatic set_rx(input bit s9, input logic v);
        if (s9) i9.rx_in = v;
        else i8.rx_in = v;
    endtask

    task automatic set_cfg(input bit s9, input logic [5:0] p, input logic pen, input logic ptyp, input logic st2);
        if (s9) begin
            i9.prescale = p; i9.par_en = pen; i9.par_typ = ptyp; i9.stop2 = st2;
        end else begin
            i8.prescale = p; i8.par_en = pen; i8.par_typ = ptyp; i8.stop2 = st2;
        end
    endtask

    task automatic expect_ev(input bit s9, input logic [3:0] fl, input logic [8:0] d, input int at);
        exp_t e;
        if (fl == VALID) begin
            if (s9) last9 = d;
            else last8 = d;
        end
        e.fl  = fl;
        e.d   = s9 ? last9 : last8;
        e.cyc = at;
        if (s9) q9.push_back(e);
        else q8.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            set_rx(1'b0, 1'b1);
            set_rx(1'b1, 1'b1);
        end
    endtask

    // Drives one frame; config is scrambled after its first cycle to prove it was latched
    task automatic send(input bit s9, input logic [8:0] d, input int nd, input int p, input logic pen,
                        input logic ptyp, input logic pbit, input logic st2, input logic stopv,
                        input logic [3:0] fl);
        logic [15:0] vec;
        int n;
        int ts;
        vec = '0;
        n = 1;
        for (int i = 0; i < nd; i++) begin vec[n] = d[i]; n++; end
        if (pen) begin vec[n] = pbit; n++; end
        vec[n] = stopv; n++;
        if (st2) begin vec[n] = 1'b1; n++; end
        for (int k = 0; k < n; k++)
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) begin
                    set_cfg(s9, 6'(p), pen, ptyp, st2);
                    set_rx(s9, 1'b0);
                    ts = cyc;
                    expect_ev(s9, fl, d, ts + n * p + 1);
                end else begin
                    set_rx(s9, vec[k]);
                    if (k == 0 && c == 1) set_cfg(s9, 6'(p + 5), !pen, !ptyp, !st2);
                end
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_rx(1'b0, 1'b1);
        set_rx(1'b1, 1'b1);
        set_cfg(1'b0, 6'd8, 1'b0, 1'b0, 1'b0);
        set_cfg(1'b1, 6'd8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_p_data8", 32'(i8.p_data), 32'(0));
        check("rst_p_data9", 32'(i9.p_data), 32'(0));
        check("rst_flags8", 32'(fl8), 32'(0));
        check("rst_flags9", 32'(fl9), 32'(0));
        check("rst_busy8", 32'(i8.busy), 32'(0));
        rst_n = 1'b1;
        idle(4);

        send(1'b0, 9'h055, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, VALID);
        idle(5);
        send(1'b0, 9'h0A3, 8, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, VALID);
        idle(5);
        send(1'b0, 9'h0A3, 8, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PERR);
        idle(5);
        send(1'b0, 9'h00F, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, VALID);
        idle(5);

        send(1'b0, 9'h012, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SERR);
        repeat (40) begin @(negedge clk); set_rx(1'b0, 1'b0); end
        repeat (5) begin @(negedge clk); set_rx(1'b0, 1'b1); end
        @(negedge clk); set_rx(1'b0, 1'b0);
        check("busy_err_low", 32'(i8.busy), 32'(1));
        @(negedge clk); set_rx(1'b0, 1'b1);
        repeat (7) @(negedge clk);
        check("busy_err_hold", 32'(i8.busy), 32'(1));
        @(negedge clk);
        check("busy_err_done", 32'(i8.busy), 32'(0));
        idle(5);

        @(negedge clk);
        set_cfg(1'b0, 6'd16, 1'b0, 1'b0, 1'b0);
        set_rx(1'b0, 1'b0);
        t = cyc;
        expect_ev(1'b0, GLTCH, 9'h0, t + 17);
        repeat (2) begin @(negedge clk); set_rx(1'b0, 1'b0); end
        @(negedge clk); set_rx(1'b0, 1'b1);
        repeat (15) @(negedge clk);
        check("busy_glitch", 32'(i8.busy), 32'(0));
        idle(5);

        send(1'b1, 9'h1FF, 9, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, VALID);
        send(1'b1, 9'h000, 9, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, VALID);
        idle(10);
        send(1'b1, 9'h15A, 9, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, VALID);
        idle(10);

        @(negedge clk);
        set_cfg(1'b0, 6'd8, 1'b0, 1'b0, 1'b0);
        set_rx(1'b0, 1'b0);
        repeat (7) @(negedge clk);
        repeat (24) begin @(negedge clk); set_rx(1'b0, 1'b1); end
        check("busy_mid", 32'(i8.busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_p_data", 32'(i8.p_data), 32'(0));
        check("mid_rst_busy", 32'(i8.busy), 32'(0));
        check("mid_rst_flags", 32'(fl8), 32'(0));
        last8 = '0;
        last9 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        send(1'b0, 9'h03C, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, VALID);
        idle(10);

        check("left8", 32'(q8.size()), 32'(0));
        check("left9", 32'(q9.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Parametrised UART receive frame controller: oversamples `rx_in`, majority-votes each bit, deserialises a configurable-width LSB-first frame, and checks start, optional even/odd parity, and one or two stop bits. It is the next-generation RX path in the UART block of the multi-clock system. Counters, sampler, deserialiser and checkers are integrated into one block, and it adds runtime parity type, a two-stop-bit mode and explicit error recovery. It sits in the UART RX clock domain and feeds the data synchroniser with a one-cycle `data_valid` pulse.

## Interface
- `DATA_W`, 8, data bits per frame; legal range 5..9.
- `PRESCALE_W`, 6, width of the oversampling ratio input.
- `clk`  in  1  RX oversampling clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `rx_in`  in  1  serial line; idles high.
- `prescale`  in  PRESCALE_W  clocks per bit; legal 8..32; values below 8 behave as 8.
- `par_en`  in  1  1 = a parity bit follows the data bits.
- `par_typ`  in  1  0 = even parity, 1 = odd parity.
- `stop2`  in  1  1 = two stop bits are checked.
- `p_data`  out  DATA_W  last good frame; updated only on a good frame.
- `data_valid`  out  1  one-cycle pulse when `p_data` is updated.
- `par_err`  out  1  one-cycle pulse at frame end on a parity mismatch.
- `stp_err`  out  1  one-cycle pulse when a stop bit samples 0.
- `strt_glitch`  out  1  one-cycle pulse when the start bit is not confirmed.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Frame config latch:** `prescale`, `par_en`, `par_typ` and `stop2` are latched on the IDLE->START transition and held for the whole frame. Changes mid-frame have no effect.
- **Counters:**
  - `edge_cnt` counts 0..P-1, where P is the latched prescale.
  - `last_edge` is true when `edge_cnt == P-1`. `edge_cnt` wraps to 0 on the next cycle.
  - `bit_cnt` counts the data bits received.
- **Sampler:**
  - Let h = P>>1. `rx_in` is captured at `edge_cnt` = h-1, h and h+1.
  - The voted bit is the majority (2 of 3) of those three samples. It is stable from `edge_cnt` = h+2 and is used at `last_edge`.
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2, ERROR.
  - **IDLE:** `rx_in` == 0 -> START, with `edge_cnt` = 0 in the first START cycle.
  - **START:** at `last_edge`:
    - voted bit 1 -> pulse `strt_glitch`, go to IDLE;
    - voted bit 0 -> DATA.
  - **DATA:** at each `last_edge`, the voted bit is shifted in LSB-first. After DATA_W bits:
    - `par_en` -> PARITY;
    - otherwise -> STOP1.
  - **PARITY:** expected bit = XOR(data) XOR `par_typ`. A mismatch sets an internal `par_bad` flag and does not abort the frame. At `last_edge` -> STOP1.
  - **STOP1 / STOP2:** at `last_edge`:
    - voted bit 0 -> pulse `stp_err` (and `par_err` if `par_bad`), go to ERROR;
    - voted bit 1 with `stop2` in STOP1 -> STOP2;
    - otherwise the frame ends.
  - **Frame end:**
    - `par_bad` -> pulse `par_err`, `p_data` unchanged.
    - Else load `p_data` and pulse `data_valid`.
    - Next state: `rx_in` == 0 in that same cycle -> START (back-to-back frame, `edge_cnt` restarts at 0); otherwise IDLE.
  - **ERROR:** hold until `rx_in` is 1 for one full bit time (P consecutive cycles), then go to IDLE. Any 0 restarts the count.
- **Reset:** any state -> IDLE. `edge_cnt`, `bit_cnt`, the shift register, `par_bad` and all outputs are cleared. `p_data` resets to 0.

## Timing
- Reset values: `p_data` = 0; `data_valid`, `par_err`, `stp_err`, `strt_glitch` and `busy` = 0.
- All outputs are registered.
- Let t be the IDLE cycle in which `rx_in` is first seen low, and N = 1 + DATA_W + `par_en` + 1 + `stop2`.
  - The final `last_edge` falls at cycle t + N·P.
  - `data_valid`, `par_err` and `stp_err` are high during cycle t + N·P + 1.
  - `strt_glitch` is high during cycle t + P + 1.
- `busy` is high from cycle t+1 until the state returns to IDLE.
- `data_valid` and `par_err` never assert in the same cycle.
- `par_err` and `stp_err` may assert together.
- Back-to-back frames need no idle gap: the new START begins the cycle after the final `last_edge`.
- A frame aborted by reset produces no pulses.

## Test plan
- **Basic frame:** DATA_W=8, P=8, no parity, 0x55 sent LSB-first -> `data_valid` high exactly at cycle t+81, `p_data`=0x55.
- **Parity:** DATA_W=8, P=16, `par_en`=1, `par_typ`=1.
  - 0xA3 with parity bit 1 -> `data_valid`, `p_data`=0xA3.
  - Same frame with parity bit 0 -> `par_err` pulse only, `p_data` keeps 0xA3.
- **Stop error and recovery:** stop bit driven 0, then line held 0 for 40 cycles, then 1 -> `stp_err` pulse. `busy` stays high until P high cycles have elapsed, then IDLE.
- **Start glitch:** P=16, `rx_in` low for only 3 cycles -> `strt_glitch` at t+17, no `data_valid`, state returns to IDLE.
- **Back-to-back, two stop bits:** DATA_W=9, `stop2`=1, frames 0x1FF then 0x000 with no gap -> two `data_valid` pulses exactly 12·P cycles apart with correct data.
- **Reset mid-frame:** `rst_n` low during DATA -> all outputs 0 immediately and state IDLE. The next full frame 0x3C is received correctly.
